// File: rtl/decode_branch_unit.sv
// Decode-stage branch resolver: resolves bne/blt/j/jal/jr/bex in D, registers the
// PC redirect (doubling as squash), and stalls on load-use / multdiv operand hazards.
module decode_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      fd_pc,
  input  logic             fd_valid,
  input  logic [31:0]      opa,
  input  logic [31:0]      opb,
  input  logic [31:0]      op30,
  input  logic [31:0]      dx_ir,
  input  logic             md_busy,
  input  logic [4:0]       md_rd,
  output logic             stall,
  output logic             squash,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;
  localparam logic [4:0] OP_LW  = 5'b01000;

  typedef enum logic [1:0] {RUN, LD_STALL, MD_WAIT} state_t;

  state_t           state_q, state_d;
  logic             redir_q, redir_d;
  logic [31:0]      rpc_q, rpc_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] stallc_q, stallc_d;

  logic [4:0]  op, rega, regb, dx_rd;
  logic        use_a, use_b, use_30;
  logic        ld_haz, md_haz, resolve, taken;
  logic [31:0] n_ext, t_ext, target;
  logic        unused_dx;

  assign op        = fd_ir[31:27];
  assign rega      = fd_ir[26:22];
  assign regb      = fd_ir[21:17];
  assign dx_rd     = dx_ir[26:22];
  assign unused_dx = ^dx_ir[21:0];
  assign n_ext     = {{15{fd_ir[16]}}, fd_ir[16:0]};
  assign t_ext     = {5'b0, fd_ir[26:0]};

  assign use_a  = (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
  assign use_b  = (op == OP_BNE) || (op == OP_BLT);
  assign use_30 = (op == OP_BEX);

  // $0 is filtered by the nonzero-rd terms, so a hardwired-zero source never hazards
  assign ld_haz = (dx_ir[31:27] == OP_LW) && (dx_rd != 5'd0) &&
                  ((use_a && dx_rd == rega) || (use_b && dx_rd == regb) ||
                   (use_30 && dx_rd == 5'd30));
  assign md_haz = md_busy && (md_rd != 5'd0) &&
                  ((use_a && md_rd == rega) || (use_b && md_rd == regb) ||
                   (use_30 && md_rd == 5'd30));

  assign stall   = fd_valid && (ld_haz || md_haz);
  assign resolve = fd_valid && !stall && !redir_q;

  always_comb begin
    taken  = 1'b0;
    target = t_ext;
    unique case (op)
      OP_BNE: begin taken = (opa != opb);                   target = fd_pc + 32'd1 + n_ext; end
      OP_BLT: begin taken = ($signed(opa) < $signed(opb));  target = fd_pc + 32'd1 + n_ext; end
      OP_J, OP_JAL: taken = 1'b1;
      OP_JR:  begin taken = 1'b1;                           target = opa; end
      OP_BEX: taken = (op30 != 32'd0);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    redir_d  = resolve && taken;
    rpc_d    = (resolve && taken) ? target : rpc_q;
    taken_d  = (resolve && taken && !(&taken_q)) ? taken_q + 1'b1 : taken_q;
    stallc_d = (stall && !(&stallc_q)) ? stallc_q + 1'b1 : stallc_q;
    unique case (state_q)
      RUN: begin
        if (fd_valid && ld_haz)      state_d = LD_STALL;
        else if (fd_valid && md_haz) state_d = MD_WAIT;
      end
      LD_STALL: state_d = RUN;
      MD_WAIT:  if (!(fd_valid && md_haz)) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
      taken_q  <= '0;
      stallc_q <= '0;
    end else begin
      state_q  <= state_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
      taken_q  <= taken_d;
      stallc_q <= stallc_d;
    end
  end

  assign redirect_valid = redir_q;
  assign squash         = redir_q;
  assign redirect_pc    = rpc_q;
  assign taken_count    = taken_q;
  assign stall_count    = stallc_q;

endmodule

// File: tb/tb_decode_branch_unit.sv
// Directed bench for decode_branch_unit; a CNT_W=4 twin shares the stimulus to reach saturation quickly.
module tb_decode_branch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_ir, fd_pc, opa, opb, op30, dx_ir;
  logic        fd_valid, md_busy;
  logic [4:0]  md_rd;
  logic        stall, squash, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] taken_count, stall_count;
  logic        s_stall, s_squash, s_rv;
  logic [31:0] s_rpc;
  logic [3:0]  s_taken, s_stallc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  decode_branch_unit #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .fd_pc(fd_pc), .fd_valid(fd_valid),
    .opa(opa), .opb(opb), .op30(op30), .dx_ir(dx_ir), .md_busy(md_busy), .md_rd(md_rd),
    .stall(stall), .squash(squash), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .taken_count(taken_count), .stall_count(stall_count));

  decode_branch_unit #(.CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .fd_pc(fd_pc), .fd_valid(fd_valid),
    .opa(opa), .opb(opb), .op30(op30), .dx_ir(dx_ir), .md_busy(md_busy), .md_rd(md_rd),
    .stall(s_stall), .squash(s_squash), .redirect_valid(s_rv),
    .redirect_pc(s_rpc), .taken_count(s_taken), .stall_count(s_stallc));

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [16:0] imm);
    return {op, ra, rb, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; fd_ir = '0; fd_pc = '0; fd_valid = 1'b0; opa = '0; opb = '0;
    op30 = '0; dx_ir = '0; md_busy = 1'b0; md_rd = '0;
    #12;
    chk("rst_rv", redirect_valid, 0);
    chk("rst_sq", squash, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_taken", taken_count, 0);
    chk("rst_stallc", stall_count, 0);
    reset = 1'b1;
    tick();

    // bne r1,r2,+5 at pc=10, taken
    fd_ir = ins(5'b00010, 5'd1, 5'd2, 17'd5); fd_pc = 32'd10; opa = 32'd3; opb = 32'd4;
    fd_valid = 1'b1; #1;
    chk("bne_nostall", stall, 0);
    tick();
    chk("bne_rv", redirect_valid, 1);
    chk("bne_sq", squash, 1);
    chk("bne_rpc", redirect_pc, 32'd16);
    chk("bne_taken", taken_count, 1);
    fd_valid = 1'b0; tick();
    chk("bne_rv_drop", redirect_valid, 0);
    chk("bne_rpc_hold", redirect_pc, 32'd16);

    // blt signed: -1 < 0 taken; 0 < -1 not taken
    fd_ir = ins(5'b00110, 5'd1, 5'd2, 17'd0); fd_pc = 32'd100;
    opa = 32'hFFFF_FFFF; opb = 32'd0; fd_valid = 1'b1;
    tick();
    chk("blt_neg_rv", redirect_valid, 1);
    chk("blt_neg_rpc", redirect_pc, 32'd101);
    fd_valid = 1'b0; tick();
    opa = 32'd0; opb = 32'hFFFF_FFFF; fd_valid = 1'b1;
    tick();
    chk("blt_pos_rv", redirect_valid, 0);
    chk("blt_pos_taken", taken_count, 2);

    // bne backward, N = -2 at pc 50 -> 49
    fd_ir = ins(5'b00010, 5'd1, 5'd2, 17'h1FFFE); fd_pc = 32'd50; opa = 32'd1; opb = 32'd2;
    tick();
    chk("bne_back_rpc", redirect_pc, 32'd49);
    fd_valid = 1'b0; tick();

    // load-use: lw r5 in D/X, bne r5,r6 in F/D
    dx_ir = ins(5'b01000, 5'd5, 5'd0, 17'd0);
    fd_ir = ins(5'b00010, 5'd5, 5'd6, 17'd3); fd_pc = 32'd200; opa = 32'd1; opb = 32'd2;
    fd_valid = 1'b1; #1;
    chk("ld_stall", stall, 1);
    tick();
    chk("ld_rv_held", redirect_valid, 0);
    chk("ld_stallc", stall_count, 1);
    dx_ir = '0; #1;
    chk("ld_stall_gone", stall, 0);
    tick();
    chk("ld_rv", redirect_valid, 1);
    chk("ld_rpc", redirect_pc, 32'd204);
    chk("ld_taken", taken_count, 4);
    fd_valid = 1'b0; tick();

    // lw r0 never hazards
    dx_ir = ins(5'b01000, 5'd0, 5'd0, 17'd0);
    fd_ir = ins(5'b00010, 5'd0, 5'd6, 17'd3); opa = 32'd5; opb = 32'd5; fd_valid = 1'b1; #1;
    chk("r0_nostall", stall, 0);
    tick();
    chk("r0_stallc", stall_count, 1);
    fd_valid = 1'b0; dx_ir = '0; tick();

    // multdiv busy on r7 for 4 cycles, jr r7
    md_busy = 1'b1; md_rd = 5'd7; fd_ir = ins(5'b00100, 5'd7, 5'd0, 17'd0);
    opa = 32'h777; fd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("md_stall", stall, 1);
      tick();
    end
    chk("md_rv_held", redirect_valid, 0);
    md_busy = 1'b0; #1;
    chk("md_stall_gone", stall, 0);
    tick();
    chk("md_rv", redirect_valid, 1);
    chk("md_rpc", redirect_pc, 32'h777);
    chk("md_stallc", stall_count, 5);
    fd_valid = 1'b0; tick();

    // bex
    fd_ir = {5'b10110, 27'h123}; op30 = 32'd0; fd_valid = 1'b1;
    tick();
    chk("bex0_rv", redirect_valid, 0);
    op30 = 32'd1;
    tick();
    chk("bex1_rv", redirect_valid, 1);
    chk("bex1_rpc", redirect_pc, 32'h123);
    fd_valid = 1'b0; tick();

    // back-to-back jal, second is wrong-path
    fd_ir = {5'b00011, 27'h456}; fd_valid = 1'b1;
    tick();
    chk("jal1_rpc", redirect_pc, 32'h456);
    fd_ir = {5'b00011, 27'h789};
    tick();
    chk("jal2_rv", redirect_valid, 0);
    chk("jal2_rpc", redirect_pc, 32'h456);
    chk("jal2_taken", taken_count, 7);
    fd_valid = 1'b0; tick();

    // j uses no sources: lw r3 in D/X with rega field = 3 must not stall
    dx_ir = ins(5'b01000, 5'd3, 5'd0, 17'd0);
    fd_ir = {5'b00001, 27'hC00055}; fd_valid = 1'b1; #1;
    chk("j_nostall", stall, 0);
    tick();
    chk("j_rpc", redirect_pc, 32'hC00055);
    fd_valid = 1'b0; dx_ir = '0; tick();

    // async reset while a redirect is pending
    fd_ir = {5'b00011, 27'h999}; fd_valid = 1'b1;
    tick();
    chk("pre_rst_rv", redirect_valid, 1);
    #2 reset = 1'b0; #1;
    chk("arst_rv", redirect_valid, 0);
    chk("arst_sq", squash, 0);
    chk("arst_rpc", redirect_pc, 0);
    chk("arst_taken", taken_count, 0);
    fd_valid = 1'b0; tick();
    reset = 1'b1; tick();

    // saturation on the narrow twin
    fd_ir = {5'b00001, 27'h10};
    for (int i = 0; i < 17; i++) begin
      fd_valid = 1'b1; tick();
      fd_valid = 1'b0; tick();
    end
    chk("sat_taken_wide", taken_count, 17);
    chk("sat_taken_narrow", s_taken, 4'hF);
    md_busy = 1'b1; md_rd = 5'd7; fd_ir = ins(5'b00100, 5'd7, 5'd0, 17'd0); fd_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stallc_wide", stall_count, 20);
    chk("sat_stallc_narrow", s_stallc, 4'hF);
    md_busy = 1'b0; fd_valid = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
